// File: rtl/tcm4671_pkg.sv
// rtl/tcm4671_pkg.sv - shared widths, command struct and FSM states for the TCM4671 command sequencer
package tcm4671_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 32;
  localparam int DATAGRAM_W = 40;

  // Same bit layout as the SPI datagram: {write, addr, data}
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    GAP
  } state_t;

endpackage

// File: rtl/tcm4671_cmd_fifo.sv
// rtl/tcm4671_cmd_fifo.sv - synchronous command FIFO with registered occupancy count
module tcm4671_cmd_fifo
  import tcm4671_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  cmd_t                     i_din,
  input  logic                     i_pop,
  output cmd_t                     o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Overflow/underflow protection: requests against a full/empty FIFO are dropped
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/tcm4671_cmd_sequencer.sv
// rtl/tcm4671_cmd_sequencer.sv - buffers host register commands and issues them as spaced SPI datagrams
module tcm4671_cmd_sequencer
  import tcm4671_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [6:0]                  cmd_addr,
  input  logic [31:0]                 cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [6:0]                  rsp_addr,
  output logic [31:0]                 rsp_data,
  output logic                        spi_start,
  output logic [39:0]                 spi_datagram,
  input  logic                        spi_done,
  input  logic [31:0]                 spi_rdata,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            r_state;
  state_t            w_next;
  cmd_t              w_in;
  cmd_t              w_head;
  cmd_t              r_datagram;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] r_rsp_data;
  logic [GW-1:0]     r_gap_cnt;

  // Read data field is zeroed at enqueue so the FIFO head is already the final datagram
  assign w_in      = {cmd_write, cmd_addr, (cmd_write ? cmd_wdata : 32'h0)};
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_data  = r_rsp_data;
  // During ISSUE the datagram comes straight from the FIFO head, afterwards from the held copy
  assign spi_datagram = (r_state == ISSUE) ? w_head : r_datagram;

  tcm4671_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    w_next    = r_state;
    spi_start = 1'b0;
    rsp_valid = 1'b0;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_next = ISSUE;
      end
      ISSUE: begin
        spi_start = 1'b1;
        w_pop     = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (spi_done) w_next = r_write ? GAP : RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = GAP;
      end
      GAP: begin
        if (r_gap_cnt == '0) w_next = w_empty ? IDLE : ISSUE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Transaction context, read result capture and inter-datagram gap counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_datagram <= '0;
      r_rsp_addr <= '0;
      r_rsp_data <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (r_state == ISSUE) begin
        r_write    <= w_head.write;
        r_addr     <= w_head.addr;
        r_datagram <= w_head;
      end
      if ((r_state == WAIT) && spi_done && !r_write) begin
        r_rsp_addr <= r_addr;
        r_rsp_data <= spi_rdata;
      end
      // Held at GAP_CYCLES-1 outside GAP so it is already loaded on entry
      if (r_state != GAP)         r_gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (r_gap_cnt != '0)   r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

endmodule
